ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
Two-requester arbiter and sequencer for the single-port data RAM. Master 0 is the core data port (lw/sw); master 1 is a loader/debug port that preloads or inspects data memory. Grants access round-robin, drives the RAM enables, waits out the read latency, and returns a one-cycle ready to the winner.

Parameters:
DATA_W, 32, data word width
ADDR_W, 10, RAM word-address width
RD_LAT, 1, RAM read latency in cycles (1..3)
STAT_W, 16, width of statistics counters (ARB_STATS_EN only)

Ports:
CLK  in  1  clock, all logic on rising edge
RESET  in  1  synchronous, active-high reset
m0_req  in  1  master 0 request; held until m0_ready
m0_we  in  1  master 0 write(1)/read(0)
m0_addr  in  ADDR_W  master 0 address
m0_wdata  in  DATA_W  master 0 write data
m0_ready  out  1  one-cycle completion pulse to master 0
m1_req, m1_we, m1_addr, m1_wdata, m1_ready  same as master 0, for master 1
rdata  out  DATA_W  read data; valid only while m0_ready or m1_ready is high
mem_addr  out  ADDR_W  RAM address
mem_wdata  out  DATA_W  RAM write data
mem_wren  out  1  RAM write enable
mem_rden  out  1  RAM read enable
mem_rdata  in  DATA_W  RAM read data

Behaviour:
- Clock CLK; reset RESET, synchronous, active-high.
- All outputs are registered. Reset value of every output is 0; state is IDLE; round-robin pointer last=1, so master 0 wins the first contention.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - If any req is high, pick a winner: with a single requester, that requester wins; with both, the master other than last wins.
  - Latch winner id, we, addr, wdata; update last; go to ISSUE.
  - No req: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_addr/mem_wdata driven from latched values.
  - mem_wren=we, mem_rden=!we.
  - Write: go to DONE. Read: load latency counter with RD_LAT-1, go to WAIT.
- WAIT:
  - Counter nonzero: decrement and stay.
  - Counter zero: capture mem_rdata into rdata, go to DONE.
- DONE (exactly 1 cycle): assert ready of the latched winner only; return to IDLE.
- Latency from req sampled in IDLE at edge k:
  - Write: mem_wren high in cycle k+1, ready in cycle k+2.
  - Read: mem_rden high in cycle k+1, ready in cycle k+2+RD_LAT.
- Handshake rules:
  - Requester holds req/we/addr/wdata stable until its ready pulse.
  - The transaction retires at the edge where ready=1.
  - req still high in the following IDLE is a new transaction.
  - Changes to an inputs after latching are ignored.
- Enables outside ISSUE: mem_wren and mem_rden are 0. mem_addr and mem_wdata hold their last values.
- rdata holds its last captured value; it is not cleared after writes.
- Throughput: at most one transaction per 3 cycles (write) or 3+RD_LAT cycles (read). There is no pipelining.
- Req arriving during ISSUE, WAIT or DONE waits for the next IDLE. Arbitration uses req levels at that edge only.
- Reset in any state:
  - At the next edge, return to IDLE with all outputs 0.
  - The in-flight transaction is dropped with no ready and no further enables.
  - The pointer resets.

Optional Feature:
ARB_STATS_EN:
- Adds outputs stat_grant0, stat_grant1 and stat_conflict, each STAT_W bits.
- stat_grant0/1 increment per grant to master 0/1; stat_conflict increments per IDLE arbitration with both reqs high.
- Counters saturate at all-ones and clear on RESET.
- Without the macro: ports and counters are absent, and behaviour is otherwise identical.

Decomposition:
- Package ram_arbiter_pkg holds:
  - the state enum typedef (IDLE, ISSUE, WAIT, DONE);
  - the master-id typedef (1 bit);
  - constants M0=0, M1=1.
- Sub-module ram_arb_rr: a combinational 2-way round-robin picker (inputs req0, req1, last; outputs grant id, any).
- The FSM, latches and counters stay in ram_arbiter.

Test Plan:
1. RESET=1 for 2 cycles with both reqs high -> all outputs 0 and no enables throughout; after release, m0 is granted first.
2. m0 write, addr 0x010, data 0xDEADBEEF, req at edge k -> mem_wren=1, mem_addr=0x010, mem_wdata=0xDEADBEEF in cycle k+1 only; m0_ready in k+2 only; m1_ready stays 0.
3. m1 read of addr 0x010 after test 2 (RD_LAT=1) -> mem_rden in k+1; m1_ready and rdata=0xDEADBEEF in k+3.
4. m0 and m1 both hold read reqs continuously -> grants alternate m0, m1, m0, m1; each ready arrives 4 cycles after the previous one; no master is served twice in a row.
5. RESET asserted during WAIT of an m0 read -> no m0_ready; mem_rden=0 after the edge; a subsequent m1 write completes with normal latency and m0 wins the next contention.
6. With ARB_STATS_EN and STAT_W=2: 5 contended arbitrations -> stat_conflict=3 (saturated), stat_grant0=3 (saturated), stat_grant1=2.

Source files
------------

// File: rtl/ram_arbiter_pkg.sv
// Shared types for the data-RAM arbiter: FSM state encoding and master ids.
package ram_arbiter_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  typedef logic mid_t;

  localparam mid_t M0 = 1'b0;
  localparam mid_t M1 = 1'b1;

endpackage

// File: rtl/ram_arb_rr.sv
// Combinational 2-way round-robin picker; on contention the master other than
// 'last' wins.
module ram_arb_rr
  import ram_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  mid_t last,
  output mid_t gnt_id,
  output logic any
);

  always_comb begin
    gnt_id = M0;
    if (req0 && req1) gnt_id = (last == M0) ? M1 : M0;
    else if (req1)    gnt_id = M1;
    any = req0 | req1;
  end

endmodule

// File: rtl/ram_arbiter.sv
// Two-master arbiter/sequencer for the single-port data RAM (IDLE/ISSUE/WAIT/DONE).
// Optional grant/conflict statistics counters are enabled by defining ARB_STATS_EN.
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10,
  parameter int RD_LAT = 1,
  parameter int STAT_W = 16
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_ready,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_ready,
  output logic [DATA_W-1:0] rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] stat_grant0,
  output logic [STAT_W-1:0] stat_grant1,
  output logic [STAT_W-1:0] stat_conflict
`endif
);

  typedef logic [STAT_W-1:0] stat_t;

  localparam logic [1:0] LAT_LD = 2'(RD_LAT - 1);

  state_t            r_state, w_state_nxt;
  mid_t              r_id, w_id_nxt;
  mid_t              r_last, w_last_nxt;
  logic              r_we, w_we_nxt;
  logic [1:0]        r_cnt, w_cnt_nxt;
  logic [ADDR_W-1:0] r_mem_addr, w_addr_nxt;
  logic [DATA_W-1:0] r_mem_wdata, w_wdata_nxt;
  logic [DATA_W-1:0] r_rdata, w_rdata_nxt;
  logic              r_wren, w_wren_nxt;
  logic              r_rden, w_rden_nxt;
  logic              r_rdy0, w_rdy0_nxt;
  logic              r_rdy1, w_rdy1_nxt;

  mid_t w_gnt;
  logic w_any;

  ram_arb_rr u_rr (
    .req0   (m0_req),
    .req1   (m1_req),
    .last   (r_last),
    .gnt_id (w_gnt),
    .any    (w_any)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_id_nxt    = r_id;
    w_last_nxt  = r_last;
    w_we_nxt    = r_we;
    w_cnt_nxt   = r_cnt;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    w_rdata_nxt = r_rdata;
    w_wren_nxt  = 1'b0;
    w_rden_nxt  = 1'b0;
    w_rdy0_nxt  = 1'b0;
    w_rdy1_nxt  = 1'b0;
    unique case (r_state)
      IDLE: begin
        // The RAM port registers double as the address/data latch for ISSUE.
        if (w_any) begin
          w_id_nxt    = w_gnt;
          w_last_nxt  = w_gnt;
          w_we_nxt    = (w_gnt == M1) ? m1_we    : m0_we;
          w_addr_nxt  = (w_gnt == M1) ? m1_addr  : m0_addr;
          w_wdata_nxt = (w_gnt == M1) ? m1_wdata : m0_wdata;
          w_wren_nxt  = w_we_nxt;
          w_rden_nxt  = !w_we_nxt;
          w_state_nxt = ISSUE;
        end
      end
      ISSUE: begin
        if (r_we) begin
          w_rdy0_nxt  = (r_id == M0);
          w_rdy1_nxt  = (r_id == M1);
          w_state_nxt = DONE;
        end else begin
          w_cnt_nxt   = LAT_LD;
          w_state_nxt = WAIT;
        end
      end
      WAIT: begin
        if (r_cnt != 2'd0) begin
          w_cnt_nxt = r_cnt - 2'd1;
        end else begin
          w_rdata_nxt = mem_rdata;
          w_rdy0_nxt  = (r_id == M0);
          w_rdy1_nxt  = (r_id == M1);
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state     <= IDLE;
      r_id        <= M0;
      r_last      <= M1;
      r_we        <= 1'b0;
      r_cnt       <= 2'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_rdata     <= '0;
      r_wren      <= 1'b0;
      r_rden      <= 1'b0;
      r_rdy0      <= 1'b0;
      r_rdy1      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_id        <= w_id_nxt;
      r_last      <= w_last_nxt;
      r_we        <= w_we_nxt;
      r_cnt       <= w_cnt_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
      r_rdata     <= w_rdata_nxt;
      r_wren      <= w_wren_nxt;
      r_rden      <= w_rden_nxt;
      r_rdy0      <= w_rdy0_nxt;
      r_rdy1      <= w_rdy1_nxt;
    end
  end

  assign m0_ready  = r_rdy0;
  assign m1_ready  = r_rdy1;
  assign rdata     = r_rdata;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wren  = r_wren;
  assign mem_rden  = r_rden;

`ifdef ARB_STATS_EN
  stat_t r_stat_g0, r_stat_g1, r_stat_cf;
  logic  w_arb;

  assign w_arb = (r_state == IDLE) && w_any;

  // Saturating counters: stick at all-ones rather than wrap.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_stat_g0 <= '0;
      r_stat_g1 <= '0;
      r_stat_cf <= '0;
    end else begin
      if (w_arb && w_gnt == M0 && !(&r_stat_g0)) r_stat_g0 <= r_stat_g0 + 1'b1;
      if (w_arb && w_gnt == M1 && !(&r_stat_g1)) r_stat_g1 <= r_stat_g1 + 1'b1;
      if (w_arb && m0_req && m1_req && !(&r_stat_cf)) r_stat_cf <= r_stat_cf + 1'b1;
    end
  end

  assign stat_grant0   = r_stat_g0;
  assign stat_grant1   = r_stat_g1;
  assign stat_conflict = r_stat_cf;
`endif

endmodule

// File: tb/tb_ram_arbiter.sv
// Randomized bench for ram_arbiter: transaction-timeline reference model plus RAM model.
module tb_ram_arbiter;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 10;
  localparam int RD_LAT = 1;
  localparam int STAT_W = 16;
  localparam int NCYC   = 3000;

  logic              CLK;
  logic              RESET;
  logic              m0_req, m0_we, m1_req, m1_we;
  logic [ADDR_W-1:0] m0_addr, m1_addr;
  logic [DATA_W-1:0] m0_wdata, m1_wdata;
  logic              m0_ready, m1_ready;
  logic [DATA_W-1:0] rdata, mem_wdata, mem_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_wren, mem_rden;
`ifdef ARB_STATS_EN
  logic [STAT_W-1:0] stat_grant0, stat_grant1, stat_conflict;
`endif

  ram_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT), .STAT_W(STAT_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_ready(m1_ready),
    .rdata(rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wren(mem_wren), .mem_rden(mem_rden), .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_grant0(stat_grant0), .stat_grant1(stat_grant1), .stat_conflict(stat_conflict)
`endif
  );

  // Cycle c spans [10c, 10c+10): negedge mid-cycle, posedge ends it.
  initial begin
    CLK = 1'b1;
    forever #5 CLK = ~CLK;
  end

  // RAM with RD_LAT-cycle read latency.
  logic [DATA_W-1:0] ram [1024];
  logic [DATA_W-1:0] rp  [RD_LAT];
  always @(posedge CLK) begin
    if (mem_wren) ram[mem_addr] <= mem_wdata;
    rp[0] <= mem_rden ? ram[mem_addr] : '0;
    for (int i = 1; i < RD_LAT; i++) rp[i] <= rp[i-1];
  end
  assign mem_rdata = rp[RD_LAT-1];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Reference model: per-cycle expectations scheduled at arbitration time.
  int          e_kind [NCYC+16];   // 0 none, 1 write enable, 2 read enable
  int          e_addr [NCYC+16];
  int unsigned e_wdat [NCYC+16];
  int          e_rdy  [NCYC+16];   // 0 none, 1 master0, 2 master1
  int          e_rdrd [NCYC+16];   // ready ends a read
  int unsigned mmem   [16];
  int unsigned ex_addr, ex_wdata, ex_rdata, rd_val;
  int          last, t_next;
  bit          valid, rst_prev;
  longint      st_g0, st_g1, st_cf;
  longint      st_max;

  // Master drivers.
  bit          pend  [2];
  bit          rseen [2];
  int          age   [2];
  bit          m_we  [2];
  int          m_adr [2];
  int unsigned m_dat [2];
  int          rst_left;

  task automatic check_cycle(input int c);
    if (e_kind[c] != 0) begin
      ex_addr  = e_addr[c];
      ex_wdata = e_wdat[c];
    end
    chk("wren",  64'(mem_wren),  64'(e_kind[c] == 1));
    chk("rden",  64'(mem_rden),  64'(e_kind[c] == 2));
    chk("addr",  64'(mem_addr),  64'(ex_addr));
    chk("wdata", 64'(mem_wdata), 64'(ex_wdata));
    chk("rdy0",  64'(m0_ready),  64'(e_rdy[c] == 1));
    chk("rdy1",  64'(m1_ready),  64'(e_rdy[c] == 2));
    if (e_rdy[c] != 0) begin
      if (e_rdrd[c] != 0) ex_rdata = rd_val;
      chk("rdata", 64'(rdata), 64'(ex_rdata));
    end
    if (rst_prev) chk("rst_rdata", 64'(rdata), 64'd0);
    rst_prev = 0;
`ifdef ARB_STATS_EN
    chk("st_g0", 64'(stat_grant0),   64'(st_g0));
    chk("st_g1", 64'(stat_grant1),   64'(st_g1));
    chk("st_cf", 64'(stat_conflict), 64'(st_cf));
`endif
  endtask

  task automatic model_step(input int c);
    int w, r;
    if (e_kind[c] == 1) mmem[e_addr[c] % 16] = e_wdat[c];
    if (e_kind[c] == 2) rd_val = mmem[e_addr[c] % 16];
    if (RESET) begin
      for (int i = c + 1; i < c + 10 && i < NCYC + 16; i++) begin
        e_kind[i] = 0; e_rdy[i] = 0; e_rdrd[i] = 0;
      end
      last = 1; t_next = c + 1; valid = 1; rst_prev = 1;
      ex_addr = 0; ex_wdata = 0; ex_rdata = 0;
      st_g0 = 0; st_g1 = 0; st_cf = 0;
    end else if (valid && c >= t_next && (m0_req || m1_req)) begin
      if (m0_req && m1_req) w = (last == 0) ? 1 : 0;
      else                  w = m0_req ? 0 : 1;
      last = w;
      e_kind[c+1] = (w == 1 ? m1_we : m0_we) ? 1 : 2;
      e_addr[c+1] = (w == 1) ? int'(m1_addr) : int'(m0_addr);
      e_wdat[c+1] = (w == 1) ? m1_wdata : m0_wdata;
      r = c + 2 + ((e_kind[c+1] == 1) ? 0 : RD_LAT);
      e_rdy[r]  = w + 1;
      e_rdrd[r] = (e_kind[c+1] == 2) ? 1 : 0;
      t_next = r + 1;
      if (w == 0 && st_g0 < st_max) st_g0++;
      if (w == 1 && st_g1 < st_max) st_g1++;
      if (m0_req && m1_req && st_cf < st_max) st_cf++;
    end
  endtask

  task automatic drive(input int c);
    int p;
    if (rst_left > 0) begin
      RESET = 1'b1; rst_left--;
    end else if (c > 20 && $urandom_range(0, 99) < 2) begin
      RESET = 1'b1; rst_left = $urandom_range(0, 1);
    end else begin
      RESET = 1'b0;
    end
    p = (c < 400) ? 100 : 45;
    for (int m = 0; m < 2; m++) begin
      if (pend[m] && rseen[m]) begin
        pend[m] = 0; age[m] = 0;
      end
      if (!pend[m] && $urandom_range(0, 99) < p) begin
        pend[m]  = 1;
        m_we[m]  = $urandom_range(0, 1) == 1;
        m_adr[m] = $urandom_range(0, 15);
        m_dat[m] = $urandom;
      end
      if (pend[m]) age[m]++;
      if (age[m] > 80) begin
        chk("stall", 64'(age[m]), 64'd0);
        age[m] = 0;
      end
    end
    m0_req = pend[0]; m0_we = m_we[0]; m0_addr = ADDR_W'(m_adr[0]); m0_wdata = m_dat[0];
    m1_req = pend[1]; m1_we = m_we[1]; m1_addr = ADDR_W'(m_adr[1]); m1_wdata = m_dat[1];
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = '0;
    for (int i = 0; i < 16; i++) mmem[i] = 0;
    ex_addr = 0; ex_wdata = 0; ex_rdata = 0; rd_val = 0;
    last = 1; t_next = 0; valid = 0; rst_prev = 0;
    st_g0 = 0; st_g1 = 0; st_cf = 0;
    st_max = (longint'(1) << STAT_W) - 1;
    rseen[0] = 0; rseen[1] = 0; age[0] = 0; age[1] = 0;
    // Both masters request while reset is held for two cycles.
    pend[0] = 1; m_we[0] = 1; m_adr[0] = 'h10 % 16; m_dat[0] = 32'hDEADBEEF;
    pend[1] = 1; m_we[1] = 0; m_adr[1] = 'h10 % 16; m_dat[1] = 32'h0;
    rst_left = 1;
    RESET = 1'b1;
    m0_req = 1'b1; m0_we = 1'b1; m0_addr = ADDR_W'(m_adr[0]); m0_wdata = m_dat[0];
    m1_req = 1'b1; m1_we = 1'b0; m1_addr = ADDR_W'(m_adr[1]); m1_wdata = m_dat[1];
    for (int c = 0; c < NCYC; c++) begin
      @(negedge CLK);
      if (valid) check_cycle(c);
      rseen[0] = m0_ready; rseen[1] = m1_ready;
      model_step(c);
      @(posedge CLK);
      #1;
      drive(c + 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
